// File: rtl/sand_drop_scheduler.sv
// sand_drop_scheduler: queues user drop requests, paces array frames off the
// display vsync through a programmable divider, and holds one drop per frame
// at the array inputs until the array reports the frame complete.
module sand_drop_scheduler #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable_i,
   input  logic                     vsync_i,
   input  logic [3:0]               step_div_i,
   input  logic [8:0]               resolution_i,
   input  logic                     req_valid_i,
   input  logic [8:0]               req_x_i,
   input  logic [8:0]               req_y_i,
   output logic                     req_ready_o,
   output logic                     arr_new_frame_o,
   output logic                     arr_drop_o,
   output logic [8:0]               arr_drop_x_o,
   output logic [8:0]               arr_drop_y_o,
   input  logic                     arr_new_data_i,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [CNT_W-1:0]         reject_cnt_o,
   output logic [CNT_W-1:0]         overrun_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

   typedef struct packed {
      logic [8:0] x;
      logic [8:0] y;
   } drop_t;

   state_t        state;
   drop_t         fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [3:0]    tick_cnt;
   logic          frame_due;

   logic push_hs;
   logic in_range;
   logic push;
   logic pop;
   logic due_set;
   logic launch_clr;

   // Ready only looks at registered occupancy, so a pop never frees space
   // for a push on the same edge.
   assign req_ready_o = (level_o != LW'(DEPTH));
   assign push_hs     = req_valid_i && req_ready_o;
   assign in_range    = (req_x_i < resolution_i) && (req_y_i < resolution_i);
   assign push        = push_hs && in_range;
   // Only a frame that actually carried a drop retires a FIFO entry.
   assign pop         = (state == WAIT_DONE) && arr_new_data_i && arr_drop_o;
   // >= lets a lowered divider take effect on the very next tick.
   assign due_set     = vsync_i && (tick_cnt >= step_div_i);
   assign launch_clr  = (state == LAUNCH);

   // FIFO storage: payload needs no reset, occupancy tracking covers it.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{x: req_x_i, y: req_y_i};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level_o <= level_o + LW'(1);
            2'b01:   level_o <= level_o - LW'(1);
            default: level_o <= level_o;
         endcase
      end
   end

   // Frame divider and sticky frame-due flag; a set beats the launch clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt  <= '0;
         frame_due <= 1'b0;
      end else begin
         if (vsync_i) tick_cnt <= due_set ? 4'd0 : tick_cnt + 4'd1;
         if (due_set)         frame_due <= 1'b1;
         else if (launch_clr) frame_due <= 1'b0;
      end
   end

   // Saturating reject and overrun counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         reject_cnt_o  <= '0;
         overrun_cnt_o <= '0;
      end else begin
         if (push_hs && !in_range && (reject_cnt_o != '1))
            reject_cnt_o <= reject_cnt_o + CNT_W'(1);
         // A tick landing on the launch edge re-arms the flag the launch is
         // consuming, so it is not a lost frame.
         if (due_set && frame_due && !launch_clr && (overrun_cnt_o != '1))
            overrun_cnt_o <= overrun_cnt_o + CNT_W'(1);
      end
   end

   // Frame sequencer with registered array-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         arr_new_frame_o <= 1'b0;
         arr_drop_o      <= 1'b0;
         arr_drop_x_o    <= '0;
         arr_drop_y_o    <= '0;
         busy_o          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_due && enable_i) begin
                  state           <= LAUNCH;
                  arr_new_frame_o <= 1'b1;
                  busy_o          <= 1'b1;
               end
            end
            LAUNCH: begin
               state           <= WAIT_DONE;
               arr_new_frame_o <= 1'b0;
               // Head is peeked, not popped; it retires on completion.
               if (level_o != '0) begin
                  arr_drop_o   <= 1'b1;
                  arr_drop_x_o <= fifo_mem[rd_ptr].x;
                  arr_drop_y_o <= fifo_mem[rd_ptr].y;
               end else begin
                  arr_drop_o   <= 1'b0;
               end
            end
            WAIT_DONE: begin
               if (arr_new_data_i) begin
                  state      <= IDLE;
                  arr_drop_o <= 1'b0;
                  busy_o     <= 1'b0;
               end
            end
            default: begin
               state           <= IDLE;
               arr_new_frame_o <= 1'b0;
               arr_drop_o      <= 1'b0;
               busy_o          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sand_drop_scheduler.sv
// Self-checking bench for sand_drop_scheduler: a cycle table for the basic
// drop / reject / simultaneous-event paths, then directed multi-cycle sequences.
module tb_sand_drop_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       vsync_i;
   logic [3:0] step_div_i;
   logic [8:0] resolution_i;
   logic       req_valid_i;
   logic [8:0] req_x_i;
   logic [8:0] req_y_i;
   logic       req_ready_o;
   logic       arr_new_frame_o;
   logic       arr_drop_o;
   logic [8:0] arr_drop_x_o;
   logic [8:0] arr_drop_y_o;
   logic       arr_new_data_i;
   logic       busy_o;
   logic [2:0] level_o;
   logic [7:0] reject_cnt_o;
   logic [7:0] overrun_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sand_drop_scheduler #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .vsync_i(vsync_i),
      .step_div_i(step_div_i), .resolution_i(resolution_i),
      .req_valid_i(req_valid_i), .req_x_i(req_x_i), .req_y_i(req_y_i),
      .req_ready_o(req_ready_o), .arr_new_frame_o(arr_new_frame_o),
      .arr_drop_o(arr_drop_o), .arr_drop_x_o(arr_drop_x_o),
      .arr_drop_y_o(arr_drop_y_o), .arr_new_data_i(arr_new_data_i),
      .busy_o(busy_o), .level_o(level_o), .reject_cnt_o(reject_cnt_o),
      .overrun_cnt_o(overrun_cnt_o)
   );

   typedef struct {
      logic       rs, vs, rv, dn;
      logic [8:0] x, y;
      logic       nf, dr;
      logic [8:0] dx, dy;
      logic       bz;
      logic [2:0] lv;
      logic       rd;
      logic [7:0] rj, ov;
   } vec_t;

   function automatic vec_t v(input logic rs, vs, rv, dn, input int x, y,
                              input logic nf, dr, input int dx, dy,
                              input logic bz, input int lv, input logic rd,
                              input int rj, ov);
      vec_t r;
      r.rs = rs; r.vs = vs; r.rv = rv; r.dn = dn;
      r.x = 9'(x); r.y = 9'(y);
      r.nf = nf; r.dr = dr; r.dx = 9'(dx); r.dy = 9'(dy);
      r.bz = bz; r.lv = 3'(lv); r.rd = rd; r.rj = 8'(rj); r.ov = 8'(ov);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic push1(input int x, input int y);
      req_valid_i = 1'b1; req_x_i = 9'(x); req_y_i = 9'(y);
      tick();
      req_valid_i = 1'b0;
   endtask

   // One complete frame with the array answering after 'lat' cycles.
   task automatic run_frame(input string nm, input logic exp_dr,
                            input int ex, input int ey, input int lat);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b1;
      vsync_i = 1'b1; tick(); vsync_i = 1'b0;
      while (!arr_new_frame_o && n < 20) begin tick(); n++; end
      chk({nm, "_launch_lat"}, 64'(n), 64'd1);
      tick();
      chk({nm, "_drop"}, {arr_drop_o, busy_o}, {exp_dr, 1'b1});
      if (exp_dr) chk({nm, "_xy"}, {arr_drop_x_o, arr_drop_y_o}, {9'(ex), 9'(ey)});
      repeat (lat) begin
         tick();
         if (arr_drop_o !== exp_dr || arr_new_frame_o !== 1'b0 ||
             (exp_dr && (arr_drop_x_o !== 9'(ex) || arr_drop_y_o !== 9'(ey))))
            ok = 1'b0;
      end
      chk({nm, "_hold"}, 64'(ok), 64'd1);
      arr_new_data_i = 1'b1; tick(); arr_new_data_i = 1'b0;
      chk({nm, "_done"}, {busy_o, arr_drop_o}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[29];
      rst = 1'b1; enable_i = 1'b1; vsync_i = 1'b0; step_div_i = 4'd0;
      resolution_i = 9'd32; req_valid_i = 1'b0; req_x_i = '0; req_y_i = '0;
      arr_new_data_i = 1'b0;

      //         rs vs rv dn  x  y  nf dr dx dy bz lv rd rj ov
      vt[0]  = v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
      vt[1]  = v(0, 0, 1, 0, 5, 7,  0, 0, 0, 0, 0, 1, 1, 0, 0);
      vt[2]  = v(0, 0, 1, 0, 32,0,  0, 0, 0, 0, 0, 1, 1, 1, 0);
      vt[3]  = v(0, 0, 1, 0, 3, 40, 0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[4]  = v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[5]  = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1, 2, 0);
      vt[6]  = v(0, 0, 0, 0, 0, 0,  0, 1, 5, 7, 1, 1, 1, 2, 0);
      vt[7]  = v(0, 0, 0, 0, 0, 0,  0, 1, 5, 7, 1, 1, 1, 2, 0);
      vt[8]  = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[9]  = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[10] = v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[11] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1, 2, 0);
      vt[12] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 2, 0);
      vt[13] = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[14] = v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[15] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1, 2, 0);
      vt[16] = v(0, 0, 1, 0, 4, 4,  0, 0, 0, 0, 1, 1, 1, 2, 0);
      vt[17] = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[18] = v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[19] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1, 2, 0);
      vt[20] = v(0, 0, 0, 0, 0, 0,  0, 1, 4, 4, 1, 1, 1, 2, 0);
      vt[21] = v(0, 0, 1, 1, 6, 6,  0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[22] = v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 2, 0);
      vt[23] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1, 2, 0);
      vt[24] = v(0, 1, 0, 0, 0, 0,  0, 1, 6, 6, 1, 1, 1, 2, 0);
      vt[25] = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);
      vt[26] = v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1, 2, 0);
      vt[27] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 2, 0);
      vt[28] = v(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0);

      for (int i = 0; i < 29; i++) begin
         rst = vt[i].rs; vsync_i = vt[i].vs; req_valid_i = vt[i].rv;
         arr_new_data_i = vt[i].dn; req_x_i = vt[i].x; req_y_i = vt[i].y;
         tick();
         chk($sformatf("vec%0d", i),
             {arr_new_frame_o, arr_drop_o, busy_o, level_o, req_ready_o, reject_cnt_o, overrun_cnt_o},
             {vt[i].nf, vt[i].dr, vt[i].bz, vt[i].lv, vt[i].rd, vt[i].rj, vt[i].ov});
         if (vt[i].dr)
            chk($sformatf("vec%0d_xy", i), {arr_drop_x_o, arr_drop_y_o}, {vt[i].dx, vt[i].dy});
      end
      rst = 1'b0; vsync_i = 1'b0; req_valid_i = 1'b0; arr_new_data_i = 1'b0;

      // Basic drop with a 20-cycle array response.
      do_reset();
      push1(5, 7);
      run_frame("basic", 1'b1, 5, 7, 20);
      chk("basic_level", 64'(level_o), 64'd0);

      // Fill to full, stall the 5th, accept it the cycle after the pop.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push1(10, i + 1);
         chk($sformatf("fill_lv%0d", i), {level_o, req_ready_o}, {3'(i + 1), (i < 3) ? 1'b1 : 1'b0});
      end
      req_valid_i = 1'b1; req_x_i = 9'd10; req_y_i = 9'd5;
      tick();
      chk("fill_stall", {level_o, req_ready_o}, {3'd4, 1'b0});
      vsync_i = 1'b1; tick(); vsync_i = 1'b0;
      tick();
      chk("fill_launch", 64'(arr_new_frame_o), 64'd1);
      tick();
      chk("fill_head", {arr_drop_o, arr_drop_x_o, arr_drop_y_o}, {1'b1, 9'd10, 9'd1});
      repeat (20) tick();
      chk("fill_still_full", {level_o, req_ready_o, arr_drop_o}, {3'd4, 1'b0, 1'b1});
      arr_new_data_i = 1'b1; tick(); arr_new_data_i = 1'b0;
      chk("fill_pop", {level_o, req_ready_o}, {3'd3, 1'b1});
      tick();
      chk("fill_5th_in", {level_o, req_ready_o}, {3'd4, 1'b0});
      req_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         run_frame($sformatf("drain%0d", k), 1'b1, 10, k + 2, 5);
         chk($sformatf("drain%0d_lv", k), 64'(level_o), 64'(3 - k));
      end
      run_frame("drain_empty", 1'b0, 0, 0, 3);

      // Divider of 3 and overrun, array never completes.
      do_reset();
      step_div_i = 4'd2;
      for (int i = 1; i <= 9; i++) begin
         vsync_i = 1'b1; tick(); vsync_i = 1'b0; tick();
         chk($sformatf("div_nf%0d", i), 64'(arr_new_frame_o), (i == 3) ? 64'd1 : 64'd0);
         chk($sformatf("div_ov%0d", i), 64'(overrun_cnt_o), (i == 9) ? 64'd1 : 64'd0);
      end
      chk("div_busy", 64'(busy_o), 64'd1);

      // Saturation: every vsync overruns while the frame hangs.
      step_div_i = 4'd0;
      vsync_i = 1'b1;
      repeat (10) tick();
      chk("sat_mid", 64'(overrun_cnt_o), 64'd11);
      repeat (290) tick();
      vsync_i = 1'b0; tick();
      chk("sat_end", 64'(overrun_cnt_o), 64'd255);

      // Reset mid-frame with three entries queued.
      do_reset();
      push1(7, 1); push1(7, 2); push1(7, 3);
      vsync_i = 1'b1; tick(); vsync_i = 1'b0;
      tick(); tick();
      chk("mid_wait", {busy_o, arr_drop_o, level_o}, {1'b1, 1'b1, 3'd3});
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_outs",
          {arr_new_frame_o, arr_drop_o, arr_drop_x_o, arr_drop_y_o, busy_o, level_o, reject_cnt_o, overrun_cnt_o},
          64'd0);
      chk("mid_rst_ready", 64'(req_ready_o), 64'd1);
      arr_new_data_i = 1'b1; tick(); arr_new_data_i = 1'b0;
      tick();
      chk("mid_stray", {arr_new_frame_o, arr_drop_o, busy_o, level_o}, 6'd0);

      // enable_i gates launches but keeps the frame due.
      enable_i = 1'b0;
      vsync_i = 1'b1; tick(); vsync_i = 1'b0;
      repeat (3) tick();
      chk("en_hold", {busy_o, arr_new_frame_o}, 2'b00);
      enable_i = 1'b1; tick();
      chk("en_launch", {busy_o, arr_new_frame_o}, 2'b11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sand_drop_scheduler.md
# sand_drop_scheduler

Sequencing controller in front of the tiled sandpile array engine. Queues user drop requests in a small FIFO, paces array frames from the display frame tick with a programmable divider, and drives the array's frame-start pulse and drop inputs. Holds the head-of-queue drop across the whole array frame and retires it when the array reports frame completion. Counts rejected and overrun events.

## Interface
- `DEPTH`, default 4: drop FIFO entries; a power of 2, at least 2.
- `CNT_W`, default 8: width of the saturating event counters.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `enable_i` in, 1: allows new frames to launch; does not abort a running frame.
- `vsync_i` in, 1: one-cycle display frame tick.
- `step_div_i` in, 4: one array frame per `step_div_i+1` qualifying ticks.
- `resolution_i` in, 9: active grid edge length; drop coordinates must be below it.
- `req_valid_i` in, 1: drop request valid.
- `req_x_i` in, 9: drop request column.
- `req_y_i` in, 9: drop request row.
- `req_ready_o` out, 1: FIFO not full.
- `arr_new_frame_o` out, 1: one-cycle frame-start pulse to the array.
- `arr_drop_o` out, 1: drop present for the current frame.
- `arr_drop_x_o` out, 9: drop column for the current frame.
- `arr_drop_y_o` out, 9: drop row for the current frame.
- `arr_new_data_i` in, 1: array frame-complete pulse.
- `busy_o` out, 1: high whenever state is not IDLE.
- `level_o` out, clog2(DEPTH)+1: FIFO occupancy.
- `reject_cnt_o` out, CNT_W: out-of-range requests; saturates.
- `overrun_cnt_o` out, CNT_W: frame ticks lost while a frame was still due; saturates.

## Operation
- **Push.** A push occurs on an edge where `req_valid_i && req_ready_o`.
  - If `req_x_i >= resolution_i` or `req_y_i >= resolution_i`, the entry is discarded and `reject_cnt_o` increments. The handshake still completes.
- **Ready.** `req_ready_o = (level_o != DEPTH)`, decoded from registered occupancy only. A same-cycle pop does not free space for a push.
- **Divider.**
  - `tick_cnt` increments on each `vsync_i`.
  - When `vsync_i && tick_cnt >= step_div_i`: `tick_cnt` is set to 0 and the sticky `frame_due` flag is set.
  - The `>=` comparison makes a lowered `step_div_i` take effect on the next tick.
  - If `frame_due` is already 1 when it would be set again, `overrun_cnt_o` increments.
- **FSM states.** IDLE, LAUNCH, WAIT_DONE.
  - IDLE → LAUNCH: when `frame_due && enable_i`.
  - LAUNCH: one cycle, then → WAIT_DONE.
    - `arr_new_frame_o` is high during this cycle.
    - `frame_due` is cleared.
    - If FIFO is non-empty, the head is latched into `arr_drop_x_o`/`arr_drop_y_o` and `arr_drop_o` is set to 1. Otherwise `arr_drop_o` is 0.
    - The FIFO is not popped yet.
  - WAIT_DONE → IDLE: on `arr_new_data_i`.
    - If `arr_drop_o` was 1, the FIFO pops on that same edge.
    - `arr_drop_o` clears on that edge.
- **Drop hold.** `arr_drop_o` and the coordinates stay stable for the entire frame, because the array re-samples them on every tile.
- **Stray completions.** `arr_new_data_i` outside WAIT_DONE is ignored.
- **Counters.** Both saturate at all-ones; neither wraps.
- **Counter order.** The empty-FIFO LAUNCH case takes the head (which is nothing); that is not an error.
- **Simultaneous events.**
  - Push and pop on the same edge: occupancy is unchanged and both take effect.
  - Push to an empty FIFO on the LAUNCH edge: the new entry is not seen; it waits for the next frame.
  - `vsync_i` on the LAUNCH edge: the clear of `frame_due` loses to the set. `frame_due` stays 1 and no overrun is counted.

## Timing
- **Reset values.** All outputs are 0 except `req_ready_o`, which is 1. Reset also sets state to IDLE, `tick_cnt` 0, `frame_due` 0, FIFO empty and counters 0.
- **Reset mid-frame.** Abandons the frame and the held drop.
- **All outputs registered** except `req_ready_o`, which is decoded from a register.
- **Launch latency.** A qualifying `vsync_i` sampled at edge k gives `frame_due` = 1 after k. The FSM enters LAUNCH at edge k+1, so `arr_new_frame_o` is high in cycle k+1 to k+2.
- **Completion.** `arr_new_data_i` sampled at edge m gives IDLE, pop and `arr_drop_o` = 0 after m. The earliest relaunch is edge m+1 if `frame_due` is set.
- **Occupancy.** `level_o` updates on the edge after the push or pop.

## Test plan
- **Basic drop.** `step_div_i`=0, push (5,7), pulse `vsync_i`; array model answers `arr_new_data_i` 20 cycles after `arr_new_frame_o`.
  - Required: `arr_new_frame_o` 2 cycles after vsync.
  - Required: `arr_drop_o`=1 with (5,7) held until done; `level_o` 1→0 the edge after done.
- **Fill to full.** `DEPTH`=4, push 5 requests back-to-back with no frames.
  - Required: `req_ready_o` drops after 4 pushes; the 5th is stalled; `level_o`=4.
  - Then run one frame. Required: the 5th is accepted the cycle after the pop.
- **Out of range.** `resolution_i`=32, push (32,0) and (3,40).
  - Required: `reject_cnt_o`=2, `level_o`=0, no drop in the next frame.
- **Divider and overrun.** `step_div_i`=2, 9 vsync pulses, array never completes.
  - Required: the first frame launches after the 3rd tick.
  - Required: `overrun_cnt_o`=1 after the 9th tick (6th sets `frame_due`, 9th overruns).
- **Saturation.** Force 300 overruns. Required: `overrun_cnt_o`=255 with no wrap.
- **Reset mid-frame.** Assert `rst` in WAIT_DONE with 3 entries queued.
  - Required: next cycle all outputs 0, `req_ready_o`=1, `level_o`=0.
  - Required: a stray `arr_new_data_i` afterward is ignored.
